conv2d_3_frame_scheduler: RTL and testbench

Sequences one feature-map pass through the 16-channel conv2d_3 filter bank. It issues a single common read strobe to the 16 padded-input FIFOs only when every channel has data and downstream has room. It counts (WIDTH+2)^2 padded input words and WIDTH^2 filter outputs, and tags each output with row/col. It raises done when the frame completes. It sits between the layer's input FIFO bank and the filter instances, which share one valid_in/rdreq.

---
 rtl/conv2d_3_frame_scheduler_pkg.sv | 38 +++
 rtl/conv2d_3_frame_scheduler_frame_pos_counter.sv | 56 +++++
 rtl/conv2d_3_frame_scheduler.sv | 139 +++++++++++++
 tb/tb_conv2d_3_frame_scheduler.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv2d_3_frame_scheduler_pkg.sv
// Shared definitions for the conv2d_3 layer schedulers.
//   - Scheduler state encoding (2-bit, legacy-compatible constants)
//   - Padding amount applied around each input feature map
//   - Helpers for counter widths and per-frame word totals
package conv2d_3_frame_scheduler_pkg;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StFeed  = 2'd1;
  localparam logic [1:0] StDrain = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  // One padding word on each side of every row and column.
  localparam int unsigned PAD = 2;

  // Ceiling log2; clog2(1) == 0.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    int unsigned v;
    result = 0;
    v = (value > 0) ? value - 1 : 0;
    while (v > 0) begin
      result++;
      v = v >> 1;
    end
    return result;
  endfunction

  // Padded input words consumed per frame.
  function automatic int unsigned in_total(input int unsigned width);
    return (width + PAD) * (width + PAD);
  endfunction

  // Filter outputs produced per frame.
  function automatic int unsigned out_total(input int unsigned width);
    return width * width;
  endfunction

endpackage

// File: rtl/conv2d_3_frame_scheduler_frame_pos_counter.sv
// Row/column position counter for a square feature map.
// Ports:
//   clk_i   - clock
//   rst_ni  - asynchronous active-low reset
//   clr_i   - synchronous clear to (0,0); wins over en_i
//   en_i    - advance one pixel (column first, then row)
//   row_o   - current row
//   col_o   - current column
// Both coordinates wrap at Width-1, so the counter returns to (0,0) after a full frame.
module conv2d_3_frame_scheduler_frame_pos_counter #(
  parameter int unsigned Width = 56,
  parameter int unsigned PosW  = 6
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            clr_i,
  input  logic            en_i,
  output logic [PosW-1:0] row_o,
  output logic [PosW-1:0] col_o
);

  localparam logic [PosW-1:0] Last = PosW'(Width - 1);

  logic [PosW-1:0] row_q, row_d;
  logic [PosW-1:0] col_q, col_d;

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (clr_i) begin
      row_d = '0;
      col_d = '0;
    end else if (en_i) begin
      if (col_q == Last) begin
        col_d = '0;
        row_d = (row_q == Last) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  assign row_o = row_q;
  assign col_o = col_q;

endmodule

// File: rtl/conv2d_3_frame_scheduler.sv
// Frame scheduler for the 16-channel conv2d_3 filter bank.
// Issues one common read strobe to all padded-input FIFOs (and the filters' valid_in) only
// when every channel has data and downstream has room, counts padded input words and filter
// outputs, tags each output with its row/column and pulses done at frame completion.
// Ports:
//   clk_i              - clock
//   rst_ni             - asynchronous active-low reset
//   start_i            - begins a frame when idle
//   fifo_empty_i       - per-channel input FIFO empty flags
//   out_full_i         - downstream full; pauses reads
//   filter_valid_out_i - valid from the filter bank adder stage
//   fifo_rdreq_o       - common read strobe / filter valid_in
//   out_valid_o        - qualified output-pixel write enable
//   out_row_o/out_col_o- position of the pixel being presented
//   busy_o             - frame in progress
//   done_o             - one-cycle frame-complete pulse
//   err_extra_o        - sticky: filter output outside a frame or beyond WIDTH^2
module conv2d_3_frame_scheduler
  import conv2d_3_frame_scheduler_pkg::*;
#(
  parameter int unsigned WIDTH     = 56,
  parameter int unsigned CHANNELS  = 16,
  parameter int unsigned IN_CNT_W  = clog2((WIDTH + 2) * (WIDTH + 2) + 1),
  parameter int unsigned OUT_CNT_W = clog2(WIDTH * WIDTH + 1),
  parameter int unsigned POS_W     = (WIDTH > 1) ? clog2(WIDTH) : 1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                start_i,
  input  logic [CHANNELS-1:0] fifo_empty_i,
  input  logic                out_full_i,
  input  logic                filter_valid_out_i,
  output logic                fifo_rdreq_o,
  output logic                out_valid_o,
  output logic [POS_W-1:0]    out_row_o,
  output logic [POS_W-1:0]    out_col_o,
  output logic                busy_o,
  output logic                done_o,
  output logic                err_extra_o
);

  localparam int unsigned IN_TOTAL  = in_total(WIDTH);
  localparam int unsigned OUT_TOTAL = out_total(WIDTH);

  localparam logic [IN_CNT_W-1:0]  InLast  = IN_CNT_W'(IN_TOTAL - 1);
  localparam logic [OUT_CNT_W-1:0] OutLast = OUT_CNT_W'(OUT_TOTAL - 1);
  localparam logic [OUT_CNT_W-1:0] OutEnd  = OUT_CNT_W'(OUT_TOTAL);

  logic [1:0]           state_q, state_d;
  logic [IN_CNT_W-1:0]  in_cnt_q, in_cnt_d;
  logic [OUT_CNT_W-1:0] out_cnt_q, out_cnt_d;
  logic                 err_q, err_d;

  logic in_feed;
  logic in_frame;
  logic frame_start;

  // Outputs decode straight from state so reset forces them low without a clock edge.
  always_comb begin
    in_feed      = (state_q == StFeed);
    in_frame     = in_feed || (state_q == StDrain);
    frame_start  = (state_q == StIdle) && start_i;
    // All channels read together or not at all; one empty FIFO stalls the whole bank.
    fifo_rdreq_o = in_feed && ~|fifo_empty_i && ~out_full_i;
    out_valid_o  = filter_valid_out_i && in_frame && (out_cnt_q < OutEnd);
    busy_o       = in_frame;
    done_o       = (state_q == StDone);
    err_extra_o  = err_q;
  end

  always_comb begin
    state_d   = state_q;
    in_cnt_d  = in_cnt_q;
    out_cnt_d = out_cnt_q;
    // Any filter output that could not be forwarded is an error.
    err_d     = err_q | (filter_valid_out_i & ~out_valid_o);

    if (fifo_rdreq_o) begin
      in_cnt_d = in_cnt_q + 1'b1;
    end
    if (out_valid_o) begin
      out_cnt_d = out_cnt_q + 1'b1;
    end

    case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d   = StFeed;
          in_cnt_d  = '0;
          out_cnt_d = '0;
        end
      end
      StFeed: begin
        if (fifo_rdreq_o && (in_cnt_q == InLast)) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        // Covers both the last output landing here and one that already arrived in FEED.
        if ((out_cnt_q == OutEnd) || (out_valid_o && (out_cnt_q == OutLast))) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      in_cnt_q  <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
      err_q     <= err_d;
    end
  end

  conv2d_3_frame_scheduler_frame_pos_counter #(
    .Width (WIDTH),
    .PosW  (POS_W)
  ) u_pos (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (frame_start),
    .en_i   (out_valid_o),
    .row_o  (out_row_o),
    .col_o  (out_col_o)
  );

endmodule

// File: tb/tb_conv2d_3_frame_scheduler.sv
module tb_conv2d_3_frame_scheduler;

  localparam int unsigned W    = 4;
  localparam int unsigned CH   = 16;
  localparam int          NIN  = (W + 2) * (W + 2);
  localparam int          NOUT = W * W;

  logic          clk = 1'b0;
  logic          rst_ni = 1'b0;
  logic          start = 1'b0;
  logic [CH-1:0] fifo_empty = '1;
  logic          out_full = 1'b0;
  logic          filter_valid = 1'b0;
  logic          fifo_rdreq;
  logic          out_valid;
  logic [1:0]    out_row;
  logic [1:0]    out_col;
  logic          busy;
  logic          done;
  logic          err_extra;

  always #5 clk = ~clk;

  conv2d_3_frame_scheduler #(
    .WIDTH    (W),
    .CHANNELS (CH)
  ) dut (
    .clk_i              (clk),
    .rst_ni             (rst_ni),
    .start_i            (start),
    .fifo_empty_i       (fifo_empty),
    .out_full_i         (out_full),
    .filter_valid_out_i (filter_valid),
    .fifo_rdreq_o       (fifo_rdreq),
    .out_valid_o        (out_valid),
    .out_row_o          (out_row),
    .out_col_o          (out_col),
    .busy_o             (busy),
    .done_o             (done),
    .err_extra_o        (err_extra)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: frame bookkeeping by word/pixel counts only.
  bit m_active, m_done, m_err;
  int m_reads, m_outs;

  // Last observed outputs.
  logic o_rd, o_val, o_busy, o_done, o_err;

  typedef struct {
    bit            st;
    logic [CH-1:0] emp;
    bit            fl;
    bit            fv;
    bit            rd;
    bit            val;
    bit            bsy;
    bit            dn;
  } vec_t;

  vec_t tv[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_active = 0;
    m_done   = 0;
    m_err    = 0;
    m_reads  = 0;
    m_outs   = 0;
  endtask

  // One clock: drive at negedge, compare shortly after, then advance the model.
  task automatic step(input bit st, input logic [CH-1:0] emp, input bit fl, input bit fv);
    bit e_rd, e_val;
    int pos, rb;
    @(negedge clk);
    start        = st;
    fifo_empty   = emp;
    out_full     = fl;
    filter_valid = fv;
    #1;
    e_rd  = m_active && (m_reads < NIN) && (emp == '0) && !fl;
    e_val = fv && m_active && (m_outs < NOUT);
    pos   = m_outs % NOUT;
    o_rd = fifo_rdreq; o_val = out_valid; o_busy = busy; o_done = done; o_err = err_extra;
    chk("rdreq", o_rd, e_rd);
    chk("out_valid", o_val, e_val);
    chk("busy", o_busy, m_active);
    chk("done", o_done, m_done);
    chk("err_extra", o_err, m_err);
    chk("out_row", out_row, pos / W);
    chk("out_col", out_col, pos % W);
    m_err = m_err | (fv && !e_val);
    if (m_done) begin
      m_done = 0;
    end else if (m_active) begin
      rb = m_reads;
      m_reads += e_rd;
      m_outs  += e_val;
      if (rb == NIN && m_outs == NOUT) begin
        m_active = 0;
        m_done   = 1;
      end
    end else if (st) begin
      m_active = 1;
      m_reads  = 0;
      m_outs   = 0;
    end
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    model_reset();
    #1;
    chk("rst_rdreq", fifo_rdreq, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err_extra, 0);
    chk("rst_row", out_row, 0);
    chk("rst_col", out_col, 0);
    @(negedge clk);
    start = 0; fifo_empty = '0; out_full = 0; filter_valid = 0;
    rst_ni = 1'b1;
  endtask

  // mode 0: clean, 1: empty/full stalls, 2: random, 3: seventeen filter outputs
  task automatic run_frame(input int mode);
    int c, reads, outs, dones, streak, best, last_val, done_cyc, issued;
    logic [CH-1:0] emp;
    bit fl, fv, st;
    reads = 0; outs = 0; dones = 0; streak = 0; best = 0;
    last_val = -1; done_cyc = -1; issued = 0; c = 0;
    step(1, '0, 0, 0);
    chk("busy_before_start_edge", o_busy, 0);
    while ((m_active || m_done) && c < 300) begin
      emp = '0; fl = 0; fv = 0; st = 0;
      case (mode)
        0: fv = (c >= 25 && c <= 40);
        1: begin
          emp = (c >= 10 && c <= 14) ? 16'h0200 : '0;
          fl  = (c >= 20 && c <= 22);
          fv  = (c == 21) || (c >= 30 && c <= 44);
        end
        2: begin
          emp = ($urandom_range(0, 5) == 0) ? (16'h1 << $urandom_range(0, 15)) : '0;
          fl  = ($urandom_range(0, 4) == 0);
          fv  = (issued < NOUT) && (c >= 8) && ($urandom_range(0, 1) == 1);
          st  = m_active && ($urandom_range(0, 7) == 0);
        end
        default: fv = (c >= 5 && c <= 21);
      endcase
      issued += fv;
      step(st, emp, fl, fv);
      if (c == 0) chk("busy_after_start", o_busy, 1);
      reads += o_rd;
      outs  += o_val;
      dones += o_done;
      streak = o_rd ? streak + 1 : 0;
      if (streak > best) best = streak;
      if (o_val) last_val = c;
      if (o_done) done_cyc = c;
      if (mode == 1 && c == 14) chk("in_cnt_hold", reads, 10);
      if (mode == 1 && c == 21) begin
        chk("stall_valid", o_val, 1);
        chk("stall_rdreq", o_rd, 0);
      end
      c++;
    end
    if (c >= 300) chk("frame_budget", c, 0);
    chk("frame_reads", reads, NIN);
    chk("frame_outs", outs, NOUT);
    chk("frame_dones", dones, 1);
    if (mode == 0) chk("read_streak", best, NIN);
    if (mode <= 1) chk("done_latency", done_cyc - last_val, 1);
    if (mode == 3) chk("err_17th", err_extra, 1);
  endtask

  initial begin
    int c, reads;
    model_reset();
    tv[0] = '{st:0, emp:'0,       fl:0, fv:0, rd:0, val:0, bsy:0, dn:0};
    tv[1] = '{st:1, emp:'0,       fl:0, fv:0, rd:0, val:0, bsy:0, dn:0};
    tv[2] = '{st:0, emp:'0,       fl:0, fv:0, rd:1, val:0, bsy:1, dn:0};
    tv[3] = '{st:0, emp:16'h0200, fl:0, fv:0, rd:0, val:0, bsy:1, dn:0};
    tv[4] = '{st:0, emp:'0,       fl:1, fv:0, rd:0, val:0, bsy:1, dn:0};
    tv[5] = '{st:0, emp:'0,       fl:0, fv:1, rd:1, val:1, bsy:1, dn:0};
    tv[6] = '{st:1, emp:'0,       fl:0, fv:0, rd:1, val:0, bsy:1, dn:0};

    repeat (2) @(negedge clk);
    do_reset();

    for (int i = 0; i < 7; i++) begin
      step(tv[i].st, tv[i].emp, tv[i].fl, tv[i].fv);
      chk("tv_rdreq", o_rd, tv[i].rd);
      chk("tv_valid", o_val, tv[i].val);
      chk("tv_busy", o_busy, tv[i].bsy);
      chk("tv_done", o_done, tv[i].dn);
    end
    c = 0;
    while ((m_active || m_done) && c < 300) begin
      step(0, '0, 0, (m_outs < NOUT) && (c >= 10));
      c++;
    end
    if (c >= 300) chk("tv_frame_budget", c, 0);

    run_frame(0);
    run_frame(1);
    for (int i = 0; i < 4; i++) run_frame(2);

    // Filter output while idle.
    step(0, '0, 0, 1);
    chk("idle_fv_valid", o_val, 0);
    step(0, '0, 0, 0);
    chk("idle_fv_err", o_err, 1);
    step(0, '0, 0, 0);
    chk("err_sticky", o_err, 1);

    do_reset();
    run_frame(3);

    // Reset in the middle of a frame, with 20 words read.
    do_reset();
    step(1, '0, 0, 0);
    reads = 0;
    c = 0;
    while (reads < 20 && c < 100) begin
      step(0, '0, 0, 0);
      reads += o_rd;
      c++;
    end
    chk("pre_rst_reads", reads, 20);
    @(posedge clk);
    #2;
    filter_valid = 1;
    #1;
    chk("pre_rst_rdreq", fifo_rdreq, 1);
    chk("pre_rst_busy", busy, 1);
    filter_valid = 0;
    do_reset();
    run_frame(0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got 1 expected 0");
    $fatal(1);
  end

endmodule
